mcu_io_port: RTL and testbench

Parametrised memory-mapped I/O port for the MCU. It replaces the single-level-sensitive input latch with three pieces:
- a synchronised, debounced strobe that captures switch data;
- a valid/overrun status register;
- N addressable output registers driving FPGA pins.

It sits between the MCU data bus (address/data/write/read) and the board pins, alongside the display output block.

---
 rtl/mcu_io_pkg.sv | 17 +
 rtl/mcu_io_debounce.sv | 47 ++++
 rtl/mcu_io_port.sv | 103 ++++++++++
 tb/tb_mcu_io_port.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mcu_io_pkg.sv
// Shared constants for the MCU I/O port: register offsets above the
// output bank and the STATUS bit positions.
package mcu_io_pkg;

  localparam int ST_VALID   = 0;
  localparam int ST_OVERRUN = 1;

  // INDATA and STATUS sit directly above the output register bank.
  function automatic int addr_indata(input int n_out);
    return n_out;
  endfunction

  function automatic int addr_status(input int n_out);
    return n_out + 1;
  endfunction

endpackage

// File: rtl/mcu_io_debounce.sv
// Strobe conditioning: 2-flop synchroniser, stable-time debounce counter
// and a one-cycle pulse on the debounced inactive->active transition.
module mcu_io_debounce #(
  parameter int DEBOUNCE_CYC = 16,
  parameter bit ACT_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic press
);

  localparam int   CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic INACTIVE = ACT_LOW;

  logic             sync1;
  logic             sync2;
  logic             db_raw;
  logic [CNT_W-1:0] cnt;
  logic             toggle;

  // db_raw is kept at pin polarity so the compare with sync2 needs no inversion.
  assign toggle = (sync2 != db_raw) && (cnt == CNT_W'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db_raw <= INACTIVE;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= strobe;
      sync2 <= sync1;
      press <= toggle && (db_raw == INACTIVE);
      if (sync2 == db_raw) begin
        cnt <= '0;
      end else if (toggle) begin
        db_raw <= ~db_raw;
        cnt    <= '0;
      end else if (cnt != CNT_W'(DEBOUNCE_CYC)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcu_io_port.sv
// Memory-mapped MCU I/O port: N output registers, a debounced switch
// capture register (INDATA) and a valid/overrun STATUS register.
module mcu_io_port
  import mcu_io_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int N_OUT          = 4,
  parameter int DEBOUNCE_CYC   = 16,
  parameter bit STROBE_ACT_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_enable,
  input  logic                    read_enable,
  input  logic [ADDR_W-1:0]       address,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W:0]         fpga_in,
  output logic [N_OUT*DATA_W-1:0] port_out,
  output logic                    irq
);

  localparam logic [ADDR_W-1:0] A_INDATA = ADDR_W'(addr_indata(N_OUT));
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(addr_status(N_OUT));

  logic [DATA_W-1:0] out_reg [N_OUT];
  logic [DATA_W-1:0] sw_sync1;
  logic [DATA_W-1:0] sw_sync2;
  logic [DATA_W-1:0] indata;
  logic [DATA_W-1:0] rd_data;
  logic              valid;
  logic              overrun;
  logic              capture;
  logic              sel_indata;
  logic              sel_status;
  logic              rd_indata;
  logic              wr_status;
  logic              valid_nxt;
  logic              overrun_nxt;

  mcu_io_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .ACT_LOW      (STROBE_ACT_LOW)
  ) u_strobe (
    .clk    (clk),
    .reset  (reset),
    .strobe (fpga_in[DATA_W]),
    .press  (capture)
  );

  assign sel_indata = (address == A_INDATA);
  assign sel_status = (address == A_STATUS);
  assign rd_indata  = read_enable && sel_indata;
  assign wr_status  = write_enable && sel_status;

  // A read of INDATA racing a capture hands out the old value, so the new
  // capture must stay valid and must not count as an overrun.
  assign valid_nxt   = capture || (valid && !rd_indata);
  assign overrun_nxt = (capture && valid && !rd_indata) ||
                       (overrun && !(wr_status && data_in[ST_OVERRUN]));

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (address == ADDR_W'(k)) rd_data = out_reg[k];
    end
    if (sel_indata) rd_data = indata;
    if (sel_status) begin
      rd_data[ST_VALID]   = valid;
      rd_data[ST_OVERRUN] = overrun;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_OUT; k++) out_reg[k] <= '0;
      sw_sync1 <= '0;
      sw_sync2 <= '0;
      indata   <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      irq      <= 1'b0;
      data_out <= '0;
    end else begin
      sw_sync1 <= fpga_in[DATA_W-1:0];
      sw_sync2 <= sw_sync1;
      for (int k = 0; k < N_OUT; k++) begin
        if (write_enable && (address == ADDR_W'(k))) out_reg[k] <= data_in;
      end
      if (read_enable) data_out <= rd_data;
      if (capture) indata <= sw_sync2;
      valid   <= valid_nxt;
      overrun <= overrun_nxt;
      irq     <= valid_nxt;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_port
    assign port_out[k*DATA_W +: DATA_W] = out_reg[k];
  end

endmodule

// File: tb/tb_mcu_io_port.sv
// Directed bench for mcu_io_port: bus vector table plus hand-written
// capture / debounce / reset sequences.
module tb_mcu_io_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [7:0]  address = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic [8:0]  fpga_in = 9'h100;
  logic [31:0] port_out;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int lat   = 0;

  always #5 clk = ~clk;

  mcu_io_port dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .fpga_in      (fpga_in),
    .port_out     (port_out),
    .irq          (irq)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [7:0]  addr;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
    logic [31:0] exp_port;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic bus(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    write_enable = w;
    read_enable  = r;
    address      = a;
    data_in      = d;
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    bus(1'b0, 1'b1, a, 8'h00);
    check(name, {24'h0, data_out}, {24'h0, exp});
  endtask

  // Press the active-low strobe with switches sw, hold, release and settle.
  task automatic press(input logic [7:0] sw, input int hold);
    @(negedge clk);
    fpga_in = {1'b0, sw};
    repeat (hold) @(negedge clk);
    fpga_in[8] = 1'b1;
    repeat (25) @(negedge clk);
  endtask

  // Press and, at the edge where the capture lands, put one bus op on it.
  task automatic press_with_op(input logic [7:0] sw, input logic w, input logic r,
                               input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    fpga_in = {1'b0, sw};
    repeat (lat - 1) @(negedge clk);
    write_enable = w;
    read_enable  = r;
    address      = a;
    data_in      = d;
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    repeat (20 - lat) @(negedge clk);
    fpga_in[8] = 1'b1;
    repeat (25) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'h02, 8'hA5, 8'h00, 32'h00A5_0000};
    vecs[1]  = '{1'b0, 1'b1, 8'h02, 8'h00, 8'hA5, 32'h00A5_0000};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 32'h00A5_0000};
    vecs[3]  = '{1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 32'h00A5_0000};
    vecs[4]  = '{1'b0, 1'b1, 8'h03, 8'h00, 8'h00, 32'h00A5_0000};
    vecs[5]  = '{1'b0, 1'b1, 8'h04, 8'h00, 8'h00, 32'h00A5_0000};
    vecs[6]  = '{1'b0, 1'b1, 8'h05, 8'h00, 8'h00, 32'h00A5_0000};
    vecs[7]  = '{1'b1, 1'b0, 8'h07, 8'hFF, 8'h00, 32'h00A5_0000};
    vecs[8]  = '{1'b0, 1'b1, 8'h07, 8'h00, 8'h00, 32'h00A5_0000};
    vecs[9]  = '{1'b1, 1'b1, 8'h00, 8'h5A, 8'h00, 32'h00A5_005A};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h5A, 32'h00A5_005A};
    vecs[11] = '{1'b1, 1'b0, 8'h03, 8'hC3, 8'h5A, 32'hC3A5_005A};
    vecs[12] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'hC3, 32'hC3A5_005A};
    vecs[13] = '{1'b1, 1'b0, 8'h04, 8'h99, 8'hC3, 32'hC3A5_005A};
    vecs[14] = '{1'b0, 1'b1, 8'h04, 8'h00, 8'h00, 32'hC3A5_005A};
    vecs[15] = '{1'b1, 1'b1, 8'h05, 8'hFF, 8'h00, 32'hC3A5_005A};

    repeat (3) @(negedge clk);
    check("reset_port_out", port_out, 32'h0);
    check("reset_data_out", {24'h0, data_out}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      bus(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].din);
      check($sformatf("vec%0d_data_out", i), {24'h0, data_out}, {24'h0, vecs[i].exp_dout});
      check($sformatf("vec%0d_port_out", i), port_out, vecs[i].exp_port);
      check($sformatf("vec%0d_irq", i), {31'h0, irq}, 32'h0);
    end

    // Single capture: measure latency from press, hold 20 cycles in total.
    @(negedge clk);
    fpga_in = {1'b0, 8'h3C};
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (irq && lat == 0) lat = i;
    end
    check("capture_seen", {31'h0, lat != 0}, 32'h1);
    check("capture_latency", {31'h0, (lat >= 16 && lat <= 22)}, 32'h1);
    fpga_in[8] = 1'b1;
    repeat (25) @(negedge clk);
    check("irq_after_capture", {31'h0, irq}, 32'h1);
    rd_check("status_one_capture", 8'h05, 8'h01);
    rd_check("indata_3c", 8'h04, 8'h3C);
    check("irq_cleared_by_read", {31'h0, irq}, 32'h0);
    rd_check("status_after_read", 8'h05, 8'h00);
    if (lat < 2 || lat > 20) lat = 19;

    // Short glitch must not capture.
    press(8'hE7, 10);
    check("glitch_irq", {31'h0, irq}, 32'h0);
    rd_check("glitch_status", 8'h05, 8'h00);

    // Two captures without reading -> overrun; then W1C.
    press(8'h11, 20);
    press(8'h22, 20);
    rd_check("status_overrun", 8'h05, 8'h03);
    bus(1'b1, 1'b0, 8'h05, 8'h02);
    rd_check("status_w1c", 8'h05, 8'h01);
    rd_check("indata_22", 8'h04, 8'h22);
    rd_check("status_clear", 8'h05, 8'h00);

    // Capture racing an INDATA read.
    press(8'h11, 20);
    press_with_op(8'h77, 1'b0, 1'b1, 8'h04, 8'h00);
    check("race_read_old", {24'h0, data_out}, 32'h11);
    check("race_irq", {31'h0, irq}, 32'h1);
    rd_check("race_status", 8'h05, 8'h01);
    rd_check("race_indata_new", 8'h04, 8'h77);

    // Capture with overrun pending racing a W1C of overrun: set wins.
    press(8'h55, 20);
    press_with_op(8'h66, 1'b1, 1'b0, 8'h05, 8'h02);
    rd_check("w1c_race_status", 8'h05, 8'h03);
    rd_check("w1c_race_indata", 8'h04, 8'h66);
    bus(1'b1, 1'b0, 8'h05, 8'h02);
    rd_check("w1c_race_cleared", 8'h05, 8'h00);

    // Reset mid-debounce with a write pending.
    rd_check("pre_reset_read", 8'h03, 8'hC3);
    @(negedge clk);
    fpga_in = {1'b0, 8'hAB};
    repeat (8) @(negedge clk);
    write_enable = 1'b1;
    address      = 8'h01;
    data_in      = 8'hEE;
    #2 reset = 1'b0;
    #1;
    check("midreset_port_out", port_out, 32'h0);
    check("midreset_data_out", {24'h0, data_out}, 32'h0);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    write_enable = 1'b0;
    repeat (3) @(negedge clk);
    fpga_in[8] = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    for (int a = 0; a < 6; a++) begin
      rd_check($sformatf("post_reset_addr%0d", a), 8'(a), 8'h00);
    end
    check("post_reset_irq", {31'h0, irq}, 32'h0);
    press(8'h81, 20);
    check("post_reset_capture_irq", {31'h0, irq}, 32'h1);
    rd_check("post_reset_status", 8'h05, 8'h01);
    rd_check("post_reset_indata", 8'h04, 8'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
